uart_tx: RTL

- Serial UART transmitter: accepts parallel bytes over a valid/ready handshake and drives one asynchronous serial line. Format is LSB first, 1 start bit (0), DATA_BITS data bits, optional parity, STOP_BITS stop bits (1).
- Bit timing comes from the shared external `baud` strobe: a one-`clk`-cycle pulse per bit period, the same strobe source the UART receiver uses.
- A one-entry holding register allows back-to-back frames with no idle gap.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: transmitter state names are TX_-prefixed so the receiver's own enum can coexist.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: LSB-first frame paced by the shared baud strobe; start bit on the first strobe after accept.
// One-entry hold register: tx_ready drops on accept and rises when the frame loads, so frames can run back to back.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int              IDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic            PAR_INV   = (PARITY_ODD != 0);
    localparam logic            START_LVL = ~UART_IDLE_LEVEL;

    tx_state_t              state_q, state_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;

    logic accept;
    logic frame_end;
    logic pull;
    logic parity_bit;

    // Accept needs an empty hold and pull needs a full one, so they never collide.
    assign accept     = tx_valid && !hold_full_q;
    assign frame_end  = (state_q == TX_STOP) && (stop_cnt_q == STOP_LAST);
    assign pull       = baud && hold_full_q && ((state_q == TX_IDLE) || frame_end);
    assign parity_bit = (^shift_q) ^ PAR_INV;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= TX_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            idx_q       <= '0;
            stop_cnt_q  <= 1'b0;
            tx_q        <= UART_IDLE_LEVEL;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            stop_cnt_q  <= stop_cnt_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (baud) begin
            case (state_q)
                TX_IDLE:   if (hold_full_q) state_d = TX_START;
                TX_START:  state_d = TX_DATA;
                TX_DATA:   if (idx_q == IDX_LAST) state_d = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
                TX_PARITY: state_d = TX_STOP;
                TX_STOP:   if (stop_cnt_q == STOP_LAST) state_d = hold_full_q ? TX_START : TX_IDLE;
                default:   state_d = TX_IDLE;
            endcase
        end
    end

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        stop_cnt_d  = stop_cnt_q;
        tx_d        = tx_q;
        done_d      = 1'b0;

        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
        if (pull) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
        end

        if (baud) begin
            case (state_q)
                TX_IDLE: begin
                    if (hold_full_q) tx_d = START_LVL;
                end
                TX_START: begin
                    tx_d  = shift_q[0];
                    idx_d = '0;
                end
                TX_DATA: begin
                    if (idx_q != IDX_LAST) begin
                        tx_d  = shift_q[idx_q + 1'b1];
                        idx_d = idx_q + 1'b1;
                    end else if (PARITY_EN != 0) begin
                        tx_d = parity_bit;
                    end else begin
                        tx_d       = UART_IDLE_LEVEL;
                        stop_cnt_d = 1'b0;
                    end
                end
                TX_PARITY: begin
                    tx_d       = UART_IDLE_LEVEL;
                    stop_cnt_d = 1'b0;
                end
                TX_STOP: begin
                    if (stop_cnt_q != STOP_LAST) begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end else begin
                        done_d = 1'b1;
                        tx_d   = hold_full_q ? START_LVL : UART_IDLE_LEVEL;
                    end
                end
                default: tx_d = UART_IDLE_LEVEL;
            endcase
        end
    end

    assign tx_ready = !hold_full_q;
    assign tx       = tx_q;
    assign tx_busy  = (state_q != TX_IDLE) || hold_full_q;
    assign tx_done  = done_q;

endmodule
